// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmit stage.
// The parity helper is used only when PIPO_PARITY_EN is defined.
package piso_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } piso_state_e;

   // Even parity bit: XOR of all word bits.
   // Callers zero-extend, which leaves the XOR unchanged.
   function automatic logic even_par(input logic [63:0] w);
      return ^w;
   endfunction

endpackage

// File: rtl/piso_serializer.sv
// PISO transmit stage: valid/ready word in, framed serial bits out.
// Optional trailing parity bit when PIPO_PARITY_EN is defined.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame_start,
   output logic             frame_last,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   piso_state_e      state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             accept;
   logic             data_bit;
   logic [WIDTH-1:0] shifted;

`ifdef PIPO_PARITY_EN
   logic par_q, par_d;
`endif

   // Output decode from registered state only.
   always_comb begin
      data_bit    = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
      sout        = 1'b0;
      frame_start = 1'b0;
      frame_last  = 1'b0;
      sout_valid  = (state_q != IDLE);
      if (state_q == SHIFT) begin
         sout        = data_bit;
         frame_start = (cnt_q == '0);
`ifndef PIPO_PARITY_EN
         frame_last  = (cnt_q == LAST);
`endif
      end
`ifdef PIPO_PARITY_EN
      if (state_q == PARITY) begin
         sout       = par_q;
         frame_last = 1'b1;
      end
`endif
      busy     = sout_valid;
      in_ready = (state_q == IDLE) | frame_last;
      accept   = in_valid & in_ready;
   end

   // Next-state: load on accept, shift per bit, reload on the last bit.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      shifted = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
`ifdef PIPO_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         SHIFT: begin
            if (cnt_q != LAST) begin
               shreg_d = shifted;
               cnt_d   = cnt_q + 1'b1;
            end else begin
`ifdef PIPO_PARITY_EN
               state_d = PARITY;
               shreg_d = '0;
               cnt_d   = '0;
`else
               state_d = accept ? SHIFT : IDLE;
               shreg_d = accept ? in_data : '0;
               cnt_d   = '0;
`endif
            end
         end
`ifdef PIPO_PARITY_EN
         PARITY: begin
            state_d = accept ? SHIFT : IDLE;
            shreg_d = accept ? in_data : '0;
            cnt_d   = '0;
         end
`endif
         default: begin
            if (accept) begin
               state_d = SHIFT;
               shreg_d = in_data;
               cnt_d   = '0;
            end
         end
      endcase
`ifdef PIPO_PARITY_EN
      if (accept) par_d = even_par(64'(in_data));
`endif
   end

   // State, shift register and counter; reset aborts any frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef PIPO_PARITY_EN
   // Parity bit captured with the word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) par_q <= 1'b0;
      else      par_q <= par_d;
   end
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances share stimulus
// and are checked against a queue-of-frame-bits reference model.
module tb_piso_serializer;

   localparam int W = 4;

   typedef struct packed {
      logic msb;
      logic lsb;
      logic st;
      logic lst;
   } fbit_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         rdy0, so0, sv0, fs0, fl0, bz0;
   logic         rdy1, so1, sv1, fs1, fl1, bz1;
   logic [3:0]   sipo = '0;
   logic         sipo_clr = 1'b0;

   int    checks = 0;
   int    failures = 0;
   fbit_t q[$];
   bit    acc;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy0), .sout(so0), .sout_valid(sv0),
      .frame_start(fs0), .frame_last(fl0), .busy(bz0)
   );

   piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy1), .sout(so1), .sout_valid(sv1),
      .frame_start(fs1), .frame_last(fl1), .busy(bz1)
   );

   // Stand-in for the downstream 4-bit SIPO (MSB-first).
   always @(posedge clk) begin
      if (sipo_clr)  sipo <= '0;
      else if (sv0)  sipo <= {sipo[2:0], so0};
   end

   // Append one frame for word w, built from the framing rules.
   task automatic push_frame(input logic [W-1:0] w);
      int n;
`ifdef PIPO_PARITY_EN
      n = W + 1;
`else
      n = W;
`endif
      for (int i = 0; i < n; i++) begin
         fbit_t b;
         if (i < W) begin
            b.msb = w[W-1-i];
            b.lsb = w[i];
         end else begin
            b.msb = ^w;
            b.lsb = ^w;
         end
         b.st  = (i == 0);
         b.lst = (i == n - 1);
         q.push_back(b);
      end
   endtask

   // One clock: check at negedge, then advance the model at posedge.
   task automatic step();
      logic [5:0] e0, e1, a0, a1;
      logic       er;
      @(negedge clk);
      er = (q.size() == 0) || q[0].lst;
      if (q.size() == 0) begin
         e0 = {5'b00000, er};
         e1 = e0;
      end else begin
         e0 = {q[0].msb, 1'b1, q[0].st, q[0].lst, 1'b1, er};
         e1 = {q[0].lsb, 1'b1, q[0].st, q[0].lst, 1'b1, er};
      end
      a0 = {so0, sv0, fs0, fl0, bz0, rdy0};
      a1 = {so1, sv1, fs1, fl1, bz1, rdy1};
      checks++;
      if (a0 !== e0) begin
         failures++;
         $display("FAIL msb_cycle t=%0t got=%b want=%b (sout,sv,fs,fl,busy,rdy)",
                  $time, a0, e0);
      end
      checks++;
      if (a1 !== e1) begin
         failures++;
         $display("FAIL lsb_cycle t=%0t got=%b want=%b (sout,sv,fs,fl,busy,rdy)",
                  $time, a1, e1);
      end
      acc = in_valid && er;
      @(posedge clk);
      if (q.size() != 0) void'(q.pop_front());
      if (acc) push_frame(in_data);
      #1;
   endtask

   task automatic send(input logic [W-1:0] w);
      int n;
      in_valid = 1'b1;
      in_data  = w;
      n = 0;
      do begin
         step();
         n++;
      end while (!acc && n < 20);
      if (!acc) begin
         failures++;
         $display("FAIL accept_timeout word=%h", w);
      end
   endtask

   task automatic drain();
      int n;
      in_valid = 1'b0;
      n = 0;
      while (q.size() != 0 && n < 40) begin
         step();
         n++;
      end
      step();
   endtask

   task automatic check_reset_now(input string nm);
      logic [5:0] a0, a1;
      a0 = {so0, sv0, fs0, fl0, bz0, rdy0};
      a1 = {so1, sv1, fs1, fl1, bz1, rdy1};
      checks++;
      if (a0 !== 6'b000001 || a1 !== 6'b000001) begin
         failures++;
         $display("FAIL %s got=%b/%b want=000001", nm, a0, a1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      check_reset_now("reset_state");
      @(negedge clk);
      rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
      step();
   endtask

   task automatic test_single();
      sipo_clr = 1'b1;
      step();
      sipo_clr = 1'b0;
      send(4'b1011);
      in_valid = 1'b0;
      for (int i = 0; i < W; i++) step();
      checks++;
      if (sipo !== 4'b1011) begin
         failures++;
         $display("FAIL sipo_q got=%b want=1011", sipo);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int vcnt;
      vcnt = 0;
      send(4'hA);
      send(4'h5);
      in_valid = 1'b0;
      for (int i = 0; i < 2 * W + 4; i++) begin
         if (sv0) vcnt++;
         step();
      end
`ifdef PIPO_PARITY_EN
      vcnt = vcnt + 0;
`endif
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL b2b_drain left=%0d want=0", q.size());
      end
      drain();
   endtask

   task automatic test_lsb_first();
      send(4'b0001);
      drain();
      checks++;
      if (so1 !== 1'b0 || sv1 !== 1'b0) begin
         failures++;
         $display("FAIL lsb_idle got=%b%b want=00", so1, sv1);
      end
   endtask

   task automatic test_reset_mid();
      send(4'hF);
      in_valid = 1'b0;
      step();
      #2;
      rst = 1'b0;
      #1;
      check_reset_now("reset_mid");
      q.delete();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      step();
      send(4'h3);
      drain();
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) step();
         end
         send(4'($urandom));
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_lsb_first();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
